// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram-like cache_data_* interface.
// Contents:
//   SIZE_B / SIZE_H / SIZE_W - cache_data_size encodings. 2'b11 is treated as a word.
//   resp_state_t             - responder FSM states.
//   byte_mask()              - byte-lane enable for a (size, addr[1:0]) pair. The caches use it too.
package sram_like_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } resp_state_t;

   // Half accesses pick a half by addr[1] alone, so a misaligned halfword quietly aligns down.
   function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] m;
      case (size)
         SIZE_B:  m = 4'b0001 << addr_lo;
         SIZE_H:  m = addr_lo[1] ? 4'b1100 : 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/sram_like_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances every clock. It drives random accept stalls.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset; loads seed
//   seed - reset value; must be nonzero or the register sticks at zero
//   out  - current LFSR state
module sram_like_lfsr8 (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] seed,
   output logic [7:0] out
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= seed;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign out = lfsr_q;

endmodule

// File: rtl/sram_like_mem_resp.sv
// Responder end of the sram-like cache_data_* interface. It has one outstanding transaction,
// a fixed response latency and byte-lane writes. It stands in for the AXI bridge in cache
// and core simulations.
// Optional build macro: SRAM_RESP_STALL_EN. It gates addr_ok with an LFSR bit, which gives
// random accept stalls.
// Ports:
//   clk, rst            - clock; asynchronous active-high reset (memory is not cleared)
//   cache_data_req      - request valid
//   cache_data_wr       - 1 write / 0 read
//   cache_data_size     - 00 byte, 01 half, 10/11 word
//   cache_data_addr     - byte address; bits above the word index are ignored (memory aliases)
//   cache_data_wdata    - lane-aligned write data
//   cache_data_rdata    - read data; holds until the next read completes
//   cache_data_addr_ok  - request accepted this cycle
//   cache_data_data_ok  - transaction completes this cycle (1-cycle pulse)
module sram_like_mem_resp
   import sram_like_pkg::*;
#(
   parameter int unsigned MEM_WORDS_LOG2 = 10,
   parameter int unsigned LATENCY        = 2,     // 1..15
   parameter logic [7:0]  STALL_SEED     = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cache_data_req,
   input  logic        cache_data_wr,
   input  logic [1:0]  cache_data_size,
   input  logic [31:0] cache_data_addr,
   input  logic [31:0] cache_data_wdata,
   output logic [31:0] cache_data_rdata,
   output logic        cache_data_addr_ok,
   output logic        cache_data_data_ok
);

   localparam int unsigned Depth = 1 << MEM_WORDS_LOG2;
   localparam int unsigned AW    = MEM_WORDS_LOG2 + 2;

   resp_state_t state_q, state_d;

   logic [3:0]    cnt_q, cnt_d;
   logic          wr_q, wr_d;
   logic [1:0]    size_q, size_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;

   logic [31:0] mem [Depth];

   logic                      stall_ok;
   logic                      accept;
   logic [MEM_WORDS_LOG2-1:0] rd_idx;
   logic [MEM_WORDS_LOG2-1:0] wr_idx;
   logic                      rd_is_wr;
   logic [3:0]                mask;
   logic [31:0]               mask32;

   logic unused_addr;
   assign unused_addr = ^cache_data_addr[31:AW];

`ifdef SRAM_RESP_STALL_EN
   logic [7:0] lfsr;
   logic       unused_lfsr;

   sram_like_lfsr8 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .seed (STALL_SEED),
      .out  (lfsr)
   );

   assign stall_ok    = lfsr[0];
   assign unused_lfsr = ^lfsr[7:1];
`else
   assign stall_ok = 1'b1;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign accept = cache_data_addr_ok;

   // With LATENCY==1 the FSM goes straight from IDLE to RESP. The read index then comes from
   // the live request, because addr_q has not been loaded yet.
   assign rd_idx   = (state_q == IDLE) ? cache_data_addr[AW-1:2] : addr_q[AW-1:2];
   assign rd_is_wr = (state_q == IDLE) ? cache_data_wr : wr_q;

   // Next-state and datapath next values.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               wr_d    = cache_data_wr;
               size_d  = cache_data_size;
               addr_d  = cache_data_addr[AW-1:0];
               wdata_d = cache_data_wdata;
               cnt_d   = 4'd1;
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         // cnt_q is k in cycle T+k, so leaving at LATENCY-1 puts RESP in cycle T+LATENCY.
         WAIT: begin
            if (cnt_q == 4'(LATENCY - 1)) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d == RESP && state_q != RESP && !rd_is_wr) begin
         rdata_d = mem[rd_idx];
      end
   end

   // Outputs.
   always_comb begin
      cache_data_addr_ok = cache_data_req & (state_q == IDLE) & stall_ok;
      cache_data_data_ok = (state_q == RESP);
      cache_data_rdata   = rdata_q;
   end

   assign mask   = byte_mask(size_q, addr_q[1:0]);
   assign mask32 = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
   assign wr_idx = addr_q[AW-1:2];

   // Reset forces the FSM to IDLE, so a transaction dropped by reset never writes.
   always_ff @(posedge clk) begin
      if (state_q == RESP && wr_q) begin
         mem[wr_idx] <= (mem[wr_idx] & ~mask32) | (wdata_q & mask32);
      end
   end

endmodule
